// File: rtl/conv_ctrl.sv
// Sequencing FSM for the convolution datapath: load config, accumulate each window, store, advance filter/row.
// Optional stall counter output is compiled in with `define CONV_CTRL_STALL_CNT_EN.
module conv_ctrl #(
  parameter int PCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  av_data,
  input  logic                  av_filter,
  input  logic                  co_filter,
  input  logic                  end_of_row,
  input  logic                  end_of_filter,
  input  logic                  out_ready,
  output logic                  ld_stride,
  output logic                  ld_fileSize,
  output logic                  put_data,
  output logic                  put_filter,
  output logic                  clear_sum,
  output logic                  store_buffer,
  output logic                  next_filter,
  output logic                  next_row,
  output logic                  busy,
  output logic                  done,
  output logic [PCNT_WIDTH-1:0] store_count
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [PCNT_WIDTH-1:0] stall_count
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | load stride/filter size, clear accumulator
  // ACC   | stream elements into the accumulator
  // STORE | write partial sum to the output buffer
  // ADV_F | step to the next filter at the same window
  // ADV_R | step to the next window/row, rewind filters
  // FIN   | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACC,
    STORE,
    ADV_F,
    ADV_R,
    FIN
  } state_t;

  state_t state, state_nxt;
  logic   avail;
  logic   job_start;

  assign avail     = av_data & av_filter;
  assign job_start = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_stride    = 1'b0;
    ld_fileSize  = 1'b0;
    put_data     = 1'b0;
    put_filter   = 1'b0;
    clear_sum    = 1'b0;
    store_buffer = 1'b0;
    next_filter  = 1'b0;
    next_row     = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_stride   = 1'b1;
        ld_fileSize = 1'b1;
        clear_sum   = 1'b1;
        state_nxt   = ACC;
      end
      ACC: begin
        // Both buffers are consumed in lockstep; co_filter only matters on a put.
        put_data   = avail;
        put_filter = avail;
        if (avail && co_filter) state_nxt = STORE;
      end
      STORE: begin
        store_buffer = out_ready;
        if (out_ready) begin
          if (end_of_row && end_of_filter) state_nxt = FIN;
          else if (end_of_filter)          state_nxt = ADV_R;
          else                             state_nxt = ADV_F;
        end
      end
      ADV_F: begin
        next_filter = 1'b1;
        clear_sum   = 1'b1;
        state_nxt   = ACC;
      end
      ADV_R: begin
        next_row  = 1'b1;
        clear_sum = 1'b1;
        state_nxt = ACC;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || job_start) begin
      store_count <= '0;
    end else if (store_buffer && (store_count != '1)) begin
      store_count <= store_count + 1'b1;
    end
  end

`ifdef CONV_CTRL_STALL_CNT_EN
  logic stall;

  assign stall = ((state == ACC) && !avail) || ((state == STORE) && !out_ready);

  always_ff @(posedge clk) begin
    if (rst || job_start) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed table-driven bench for conv_ctrl: per-cycle input/expected-output rows applied in a loop.
module tb_conv_ctrl;
  localparam int W = 16;

  // expected output vector: {ld_stride, ld_fileSize, put_data, put_filter, clear_sum,
  //                          store_buffer, next_filter, next_row, busy, done}
  localparam logic [9:0] O_IDLE = 10'b0000000000;
  localparam logic [9:0] O_LOAD = 10'b1100100010;
  localparam logic [9:0] O_ACC  = 10'b0000000010;
  localparam logic [9:0] O_PUT  = 10'b0011000010;
  localparam logic [9:0] O_ST   = 10'b0000010010;
  localparam logic [9:0] O_AF   = 10'b0000101010;
  localparam logic [9:0] O_AR   = 10'b0000100110;
  localparam logic [9:0] O_FIN  = 10'b0000000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, av_data = 1'b0, av_filter = 1'b0, co_filter = 1'b0;
  logic end_of_row = 1'b0, end_of_filter = 1'b0, out_ready = 1'b1;
  logic ld_stride, ld_fileSize, put_data, put_filter, clear_sum, store_buffer;
  logic next_filter, next_row, busy, done;
  logic [W-1:0] store_count;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [W-1:0] stall_count;
`endif

  always #5 clk = ~clk;

  conv_ctrl #(.PCNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .av_data(av_data), .av_filter(av_filter),
    .co_filter(co_filter), .end_of_row(end_of_row), .end_of_filter(end_of_filter),
    .out_ready(out_ready), .ld_stride(ld_stride), .ld_fileSize(ld_fileSize),
    .put_data(put_data), .put_filter(put_filter), .clear_sum(clear_sum),
    .store_buffer(store_buffer), .next_filter(next_filter), .next_row(next_row),
    .busy(busy), .done(done), .store_count(store_count)
`ifdef CONV_CTRL_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  // inputs: {rst, start, av_data, av_filter, co_filter, end_of_row, end_of_filter, out_ready}
  typedef struct {
    string      name;
    logic [7:0] in;
    logic [9:0] out;
    int         cnt;
    int         stl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   put_total = 0;
  logic [9:0] act;

  task automatic add(input string name, input logic [7:0] in, input logic [9:0] out,
                     input int cnt, input int stl);
    vec_t v;
    v.name = name; v.in = in; v.out = out; v.cnt = cnt; v.stl = stl;
    vecs.push_back(v);
  endtask

  // minimum job: start at cycle 0, put at 2, store at 3, done at 4, idle at 5
  task automatic add_min(input string p, input int prev_cnt, input int prev_stl);
    add({p, "_start"}, 8'b01_00_0_00_1, O_IDLE, prev_cnt, prev_stl);
    add({p, "_load"},  8'b00_11_0_00_1, O_LOAD, 0, 0);
    add({p, "_put"},   8'b00_11_1_00_1, O_PUT,  0, 0);
    add({p, "_store"}, 8'b00_00_0_11_1, O_ST,   0, 0);
    add({p, "_fin"},   8'b00_00_0_00_1, O_FIN,  1, 0);
    add({p, "_idle"},  8'b00_00_0_00_1, O_IDLE, 1, 0);
  endtask

  initial begin
    int c;

    add("reset", 8'b00_00_0_00_1, O_IDLE, 0, 0);
    add_min("a", 0, 0);

    // 3 elements, 2 filters, 2 rows, with start pulsed in ACC and in FIN
    c = 0;
    add("b_start", 8'b01_00_0_00_1, O_IDLE, 1, 0);
    add("b_load",  8'b00_11_0_00_1, O_LOAD, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 2; f++) begin
        for (int e = 0; e < 3; e++)
          add("b_put", {1'b0, (e == 1), 2'b11, (e == 2), 3'b001}, O_PUT, c, 0);
        add("b_store", {5'b00000, (r == 1), (f == 1), 1'b1}, O_ST, c, 0);
        c++;
        if (f == 1 && r == 1) add("b_fin",   8'b01_00_0_00_1, O_FIN, c, 0);
        else if (f == 1)      add("b_adv_r", 8'b00_11_0_00_1, O_AR,  c, 0);
        else                  add("b_adv_f", 8'b00_11_0_00_1, O_AF,  c, 0);
      end
    end
    add("b_idle", 8'b00_00_0_00_1, O_IDLE, 4, 0);

    // av_data gap of 5 cycles mid-window, then out_ready low for 3 cycles in STORE
    add("c_start", 8'b01_00_0_00_1, O_IDLE, 4, 0);
    add("c_load",  8'b00_11_0_00_1, O_LOAD, 0, 0);
    add("c_put1",  8'b00_11_0_00_1, O_PUT,  0, 0);
    for (int k = 0; k < 5; k++)
      add("c_gap", {4'b0001, (k == 2), 3'b001}, O_ACC, 0, k);
    add("c_put2",  8'b00_11_0_00_1, O_PUT, 0, 5);
    add("c_put3",  8'b00_11_1_00_1, O_PUT, 0, 5);
    for (int k = 0; k < 3; k++)
      add("c_hold", 8'b00_00_0_11_0, O_ACC, 0, 5 + k);
    add("c_store", 8'b00_00_0_11_1, O_ST,   0, 8);
    add("c_fin",   8'b00_00_0_00_1, O_FIN,  1, 8);
    add("c_idle",  8'b00_00_0_00_1, O_IDLE, 1, 8);

    // reset while in ACC with one store already counted, then a normal job
    add("d_start", 8'b01_00_0_00_1, O_IDLE, 1, 8);
    add("d_load",  8'b00_11_0_00_1, O_LOAD, 0, 0);
    add("d_put",   8'b00_11_1_00_1, O_PUT,  0, 0);
    add("d_store", 8'b00_00_0_00_1, O_ST,   0, 0);
    add("d_adv_f", 8'b00_00_0_00_1, O_AF,   1, 0);
    add("d_rst",   8'b10_00_0_00_1, O_ACC,  1, 0);
    add("d_idle",  8'b00_00_0_00_1, O_IDLE, 0, 0);
    add("d_idle2", 8'b00_00_0_00_1, O_IDLE, 0, 0);
    add_min("e", 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {rst, start, av_data, av_filter, co_filter, end_of_row, end_of_filter, out_ready} = vecs[i].in;
      #1;
      act = {ld_stride, ld_fileSize, put_data, put_filter, clear_sum,
             store_buffer, next_filter, next_row, busy, done};
      checks++;
      if (act !== vecs[i].out) begin
        errors++;
        $display("FAIL %s[%0d] outputs got %b want %b", vecs[i].name, i, act, vecs[i].out);
      end
      checks++;
      if (store_count !== W'(vecs[i].cnt)) begin
        errors++;
        $display("FAIL %s[%0d] store_count got %0d want %0d", vecs[i].name, i, store_count, vecs[i].cnt);
      end
`ifdef CONV_CTRL_STALL_CNT_EN
      checks++;
      if (stall_count !== W'(vecs[i].stl)) begin
        errors++;
        $display("FAIL %s[%0d] stall_count got %0d want %0d", vecs[i].name, i, stall_count, vecs[i].stl);
      end
`endif
      if (put_data) put_total++;
    end

    // puts: job a 1, job b 12, job c 3, job d 1, job e 1
    checks++;
    if (put_total != 18) begin
      errors++;
      $display("FAIL put_total got %0d want %0d", put_total, 18);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
# conv_ctrl

Sequencing FSM for the convolution datapath `dp`. It accepts a `start` pulse and loads stride and filter-size configuration. For every (window, filter) pair it drives IFMap/filter buffer reads into the accumulator, then commits the partial sum to the output buffer. It steps through filters and rows until the datapath reports the last row and last filter. It sits directly above `dp` and drives every one of `dp`'s controller inputs.

## Interface
- `PCNT_WIDTH`, default 16: width of the store counter and the optional stall counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a convolution job; sampled only in IDLE.
- `av_data` in 1: IFMap buffer has an element available.
- `av_filter` in 1: filter buffer has an element available.
- `co_filter` in 1: the element presented this cycle is the last element of the current filter window.
- `end_of_row` in 1: the current window is the last window position of the current row.
- `end_of_filter` in 1: the current filter is the last filter.
- `out_ready` in 1: the Psum output buffer can accept a store.
- `ld_stride`, `ld_fileSize` out 1: configuration register load strobes.
- `put_data`, `put_filter` out 1: consume one IFMap element and one filter element, and accumulate.
- `clear_sum` out 1: zero the accumulator.
- `store_buffer` out 1: write the accumulator to the Psum buffer.
- `next_filter` out 1: advance to the next filter at the same window.
- `next_row` out 1: advance the window/row and rewind to filter 0.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle job-complete pulse.
- `store_count` out `PCNT_WIDTH`: number of stores in the current job, saturating.

## Operation
- States: IDLE, LOAD, ACC, STORE, ADV_F, ADV_R, FIN.
- **IDLE**
  - All strobes are 0.
  - `start`=1 → LOAD.
  - `store_count` clears to 0 on the transition into LOAD.
- **LOAD**
  - `ld_stride`=`ld_fileSize`=`clear_sum`=1 for exactly one cycle.
  - → ACC.
- **ACC**
  - `put_data`=`put_filter`=(`av_data` & `av_filter`). This is Mealy logic; both strobes are always asserted together, never one alone.
  - If either availability signal is low, stay in ACC with no put.
  - A put with `co_filter`=1 → STORE.
  - `co_filter` without a put is ignored.
- **STORE**
  - `store_buffer`=`out_ready`.
  - While `out_ready`=0, hold in STORE.
  - On a store:
    - `end_of_row` & `end_of_filter` → FIN.
    - else `end_of_filter` → ADV_R.
    - else → ADV_F.
  - `end_of_row` and `end_of_filter` are sampled in the store cycle.
- **ADV_F**: `next_filter`=`clear_sum`=1; → ACC.
- **ADV_R**: `next_row`=`clear_sum`=1; → ACC.
- **FIN**: `done`=1; → IDLE. `start` is ignored in FIN.
- `store_count` increments on each `store_buffer` cycle and saturates at all-ones.
- `start` outside IDLE has no effect.

## Timing
- Reset values:
  - State is IDLE.
  - Every 1-bit output is 0, including `busy` and `done`.
  - `store_count` is 0.
  - The stall counter, when compiled in, is 0.
- Reset asserted mid-job returns to IDLE on the next edge with no `done` pulse. Strobes drop in the same cycle the state leaves.
- Moore outputs (all except `put_*` and `store_buffer`) decode from the registered state.
- Latency: with `start` at cycle 0:
  - LOAD strobes appear in cycle 1.
  - The first possible put is in cycle 2.
- Minimum job (1 element, 1 filter, 1 window): put at cycle 2, store at cycle 3, `done` at cycle 4, IDLE at cycle 5.
- Per-window overhead is 2 cycles beyond the elements, i.e. STORE + ADV, assuming `out_ready`=1.
- `busy` rises in the cycle after `start` is sampled. It falls in the cycle after FIN.

## Configuration
- `CONV_CTRL_STALL_CNT_EN`
  - **Defined:** adds output `stall_count` [`PCNT_WIDTH`-1:0]. It counts, saturating, every cycle spent in ACC without a put plus every cycle spent in STORE with `out_ready`=0. It clears on the transition into LOAD.
  - **Undefined:** the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then `start`: verify LOAD strobes in cycle 1 only. With `co_filter`=1 on the first put and both `end_of_*`=1, require `store_buffer` in cycle 3, `done` in cycle 4, `store_count`=1.
- 3-element windows, 2 filters, 2 rows (`end_of_filter` high on filter 1, `end_of_row` high on row 1): require 4 stores, the sequence ADV_F, ADV_R, ADV_F, then `done`, and `store_count`=4.
- Toggle `av_data` low for 5 cycles mid-window: require no `put_*` during the gap and the total put count unchanged. With `CONV_CTRL_STALL_CNT_EN`, require `stall_count`=5.
- Hold `out_ready`=0 for 3 cycles in STORE: require `store_buffer`=0 throughout the hold, exactly one store after release, and the state held in STORE.
- Assert `rst` while in ACC: the next cycle requires IDLE, all outputs 0, `store_count`=0, and no `done`. A subsequent `start` runs normally.
- Pulse `start` during ACC and during FIN: require no effect on sequence or counters.
